instr_fetch_unit: RTL and testbench

// Instruction-side front end of the single-issue MIPS core. Owns the PC, fetches 32-bit

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over a req/ack
// handshake, holds the fetched instruction until it is consumed, resolves
// j locally and accepts external redirects.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | imem_req high, waiting for imem_ack at address pc
// HOLD  | instruction presented (instr_valid=1) until consumed
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [25:0]       jidx,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetchState_t;

  localparam logic [5:0] OP_J = 6'b000010;

  fetchState_t       stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [ADDR_W-1:0] pcOutQ, pcOutD;
  logic [31:0]       instrQ, instrD;
  logic              validQ, validD;
  // dropQ marks an outstanding request whose response must be thrown away;
  // redirPcQ is where fetching resumes once that response has arrived.
  logic              dropQ, dropD;
  logic [ADDR_W-1:0] redirPcQ, redirPcD;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] nextPc;

  assign pcPlus4 = pcOutQ + ADDR_W'(4);

  // Sequential successor of the presented instruction, with j resolved here.
  always_comb begin
    nextPc = pcPlus4;
    if (instrQ[31:26] == OP_J) begin
      nextPc = {pcPlus4[ADDR_W-1:28], instrQ[25:0], 2'b00};
    end
  end

  // State register and all fetch-side data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      pcQ      <= RESET_PC;
      pcOutQ   <= RESET_PC;
      instrQ   <= '0;
      validQ   <= 1'b0;
      dropQ    <= 1'b0;
      redirPcQ <= RESET_PC;
    end else begin
      stateQ   <= stateD;
      pcQ      <= pcD;
      pcOutQ   <= pcOutD;
      instrQ   <= instrD;
      validQ   <= validD;
      dropQ    <= dropD;
      redirPcQ <= redirPcD;
    end
  end

  // Next-state logic; a redirect overrides everything decided by the case.
  always_comb begin
    stateD   = stateQ;
    pcD      = pcQ;
    pcOutD   = pcOutQ;
    instrD   = instrQ;
    validD   = validQ;
    dropD    = dropQ;
    redirPcD = redirPcQ;

    case (stateQ)
      IDLE: stateD = REQ;
      REQ: begin
        if (imem_ack) begin
          if (dropQ) begin
            dropD = 1'b0;
            pcD   = redirPcQ;
          end else begin
            instrD = imem_rdata;
            pcOutD = pcQ;
            validD = 1'b1;
            stateD = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          pcD    = nextPc;
          validD = 1'b0;
          stateD = REQ;
        end
      end
      default: stateD = IDLE;
    endcase

    if (redirect_valid) begin
      instrD = instrQ;
      pcOutD = pcOutQ;
      validD = 1'b0;
      stateD = REQ;
      if (stateQ == REQ && !imem_ack) begin
        // Address must stay put until the outstanding ack arrives.
        pcD      = pcQ;
        dropD    = 1'b1;
        redirPcD = redirect_pc;
      end else begin
        pcD   = redirect_pc;
        dropD = 1'b0;
      end
    end
  end

  assign imem_req    = (stateQ == REQ);
  assign imem_addr   = pcQ;
  assign instr_valid = validQ;
  assign instr       = instrQ;
  assign opcode      = instrQ[31:26];
  assign rs          = instrQ[25:21];
  assign rt          = instrQ[20:16];
  assign rd          = instrQ[15:11];
  assign imm         = instrQ[15:0];
  assign jidx        = instrQ[25:0];
  assign pc_out      = pcOutQ;
  assign pc_plus4    = pcPlus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized
// fetch/stall/redirect sequence checked against an address-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] pc_out, pc_plus4;

  int total = 0;
  int bad = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jidx(jidx),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Address of the instruction that follows word w fetched at pc.
  function automatic logic [31:0] successor(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (w[31:26] == 6'b000010) return {seq[31:28], w[25:0], 2'b00};
    return seq;
  endfunction

  function automatic logic [31:0] randNonJ();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'b000010) w[31:26] = 6'b100011;
    return w;
  endfunction

  task automatic waitReq(input logic [31:0] a, input string tag);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, a);
  endtask

  // Fetch w at a: ack after dly idle cycles, hold for stallCyc cycles, then
  // consume (or redirect to rpc from HOLD).
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int dly,
                       input int stallCyc, input bit redir, input logic [31:0] rpc);
    logic [31:0] nxt;
    waitReq(a, "fetch");
    for (int i = 0; i < dly; i++) begin
      tick();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, a);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("valid", 32'(instr_valid), 32'd1);
    check("instr", instr, w);
    check("opcode", 32'(opcode), 32'(w[31:26]));
    check("rs", 32'(rs), 32'(w[25:21]));
    check("rt", 32'(rt), 32'(w[20:16]));
    check("rd", 32'(rd), 32'(w[15:11]));
    check("imm", 32'(imm), 32'(w[15:0]));
    check("jidx", 32'(jidx), 32'(w[25:0]));
    check("pc_out", pc_out, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    check("hold_noreq", 32'(imem_req), 32'd0);
    stall = 1'b1;
    for (int i = 0; i < stallCyc; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, w);
      check("stall_pc", pc_out, a);
      check("stall_noreq", 32'(imem_req), 32'd0);
    end
    if (redir) begin
      redirect_valid = 1'b1;
      redirect_pc = rpc;
      stall = 1'($urandom_range(0, 1));
      nxt = rpc;
    end else begin
      stall = 1'b0;
      nxt = successor(a, w);
    end
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("consume_valid", 32'(instr_valid), 32'd0);
    check("consume_req", 32'(imem_req), 32'd1);
    check("next_addr", imem_addr, nxt);
  endtask

  // Redirect arriving in the same cycle as the ack.
  task automatic dropSame(input logic [31:0] a, input logic [31:0] target);
    waitReq(a, "dsame");
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    redirect_valid = 1'b1;
    redirect_pc = target;
    stall = 1'($urandom_range(0, 1));
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    check("dsame_valid", 32'(instr_valid), 32'd0);
    check("dsame_req", 32'(imem_req), 32'd1);
    check("dsame_addr", imem_addr, target);
  endtask

  // Redirect while a request is outstanding; ack arrives dly cycles later.
  task automatic dropLate(input logic [31:0] a, input logic [31:0] target, input int dly);
    waitReq(a, "dlate");
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      check("dlate_addr", imem_addr, a);
      check("dlate_req", 32'(imem_req), 32'd1);
      check("dlate_valid", 32'(instr_valid), 32'd0);
      if (i < dly - 1) tick();
    end
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    tick();
    imem_ack = 1'b0;
    check("dlate_drop_valid", 32'(instr_valid), 32'd0);
    check("dlate_new_req", 32'(imem_req), 32'd1);
    check("dlate_new_addr", imem_addr, target);
  endtask

  initial begin
    logic [31:0] p, w, t;
    int dly, st;

    // Reset values
    repeat (2) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    tick();
    check("idle_noreq_done", 32'(imem_req), 32'd1);

    // Sequential fetch, then lw held by a 5-cycle stall
    fetch(32'h0, randNonJ(), 1, 0, 1'b0, '0);
    fetch(32'h4, randNonJ(), 1, 0, 1'b0, '0);
    fetch(32'h8, randNonJ(), 1, 0, 1'b0, '0);
    fetch(32'hC, randNonJ(), 0, 0, 1'b0, '0);
    fetch(32'h10, 32'h8C22_0004, 1, 5, 1'b0, '0);
    check("lw_next", imem_addr, 32'h14);

    // j resolved locally
    fetch(32'h14, randNonJ(), 0, 0, 1'b1, 32'h1000_0020);
    fetch(32'h1000_0020, 32'h0800_0040, 0, 0, 1'b0, '0);
    check("j_target", imem_addr, 32'h1000_0100);

    // Redirect with same-cycle ack, then redirect during outstanding request
    fetch(32'h1000_0100, randNonJ(), 0, 1, 1'b1, 32'h40);
    dropSame(32'h40, 32'h200);
    fetch(32'h200, randNonJ(), 0, 0, 1'b1, 32'h50);
    dropLate(32'h50, 32'h300, 3);
    fetch(32'h300, randNonJ(), 1, 0, 1'b0, '0);
    fetch(32'h304, randNonJ(), 2, 0, 1'b1, 32'hFFFF_FFFC);

    // PC wraps at the top of the address space
    fetch(32'hFFFF_FFFC, randNonJ(), 0, 0, 1'b0, '0);
    check("wrap_addr", imem_addr, 32'h0);

    // Randomized mix
    p = 32'h0;
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[31:26] = 6'b000010;
      t = $urandom;
      dly = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin dropSame(p, t); p = t; end
        1: begin dropLate(p, t, int'($urandom_range(1, 3))); p = t; end
        2: begin fetch(p, w, dly, st, 1'b1, t); p = t; end
        default: begin fetch(p, w, dly, st, 1'b0, '0); p = successor(p, w); end
      endcase
    end

    // Reset in the middle of a request, stray ack after release
    waitReq(p, "pre_rst");
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(imem_req), 32'd0);
    check("rst_mid_addr", imem_addr, 32'h0);
    check("rst_mid_valid", 32'(instr_valid), 32'd0);
    tick();
    imem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("stray_valid", 32'(instr_valid), 32'd0);
    check("stray_req", 32'(imem_req), 32'd1);
    check("stray_addr", imem_addr, 32'h0);
    fetch(32'h0, randNonJ(), 1, 0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
